// File: rtl/mac_result_sink.sv
// mac_result_sink: buffers the MAC result stream in a first-word fall-through
// FIFO that drains through a ready/valid port. It also keeps sticky overflow
// status and counters for dropped samples and saturation events.
// Optional feature: define MAC_SINK_SAT_TRACK_EN to enable saturation tagging,
// the saturation FSM and the sat_events counter.
module mac_result_sink #(
   parameter int unsigned WIDTH = 28,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [WIDTH-1:0]    f,
   input  logic                       valid_in,
   output logic signed [WIDTH-1:0]    out_data,
   output logic                       out_sat,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [CNT_W-1:0]           drop_count,
   output logic [CNT_W-1:0]           sat_events,
   input  logic                       clear
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
`ifdef MAC_SINK_SAT_TRACK_EN
   localparam int unsigned MW = WIDTH + 1;
`else
   localparam int unsigned MW = WIDTH;
`endif

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    level_q, level_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [MW-1:0]    mem_q [DEPTH];

   logic          empty, full;
   logic          pop, push_acc, drop;
   logic [MW-1:0] wr_word;
   logic [MW-1:0] head_word;

   // Full/empty from the pointer wrap bits; equal low bits mean empty or full
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   end

   // Handshake decode: a pop frees the slot a same-cycle push needs when full
   always_comb begin
      pop      = !empty && out_ready;
      push_acc = valid_in && (!full || pop);
      drop     = valid_in && full && !pop;
   end

   // Pointer and occupancy next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push_acc, pop})
         2'b10:   level_d = level_q + PW'(1);
         2'b01:   level_d = level_q - PW'(1);
         default: level_d = level_q;
      endcase
   end

   // Sticky overflow and saturating drop counter; clear wins over a same-cycle drop
   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (clear) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != CntMax) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
         end
      end
   end

   // FIFO control and status registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage array; not reset, the head is masked while empty
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
      end
   end

   assign head_word = mem_q[rd_ptr_q[AW-1:0]];

`ifdef MAC_SINK_SAT_TRACK_EN
   typedef enum logic [1:0] {
      StNorm   = 2'd0,
      StSatPos = 2'd1,
      StSatNeg = 2'd2
   } sat_state_e;

   localparam logic [WIDTH-1:0] FMax = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] FMin = {1'b1, {(WIDTH-1){1'b0}}};

   sat_state_e       sat_state_q, sat_state_d;
   logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
   logic             is_max, is_min, sat_evt;

   // Extreme-value detection on the incoming sample
   always_comb begin
      is_max  = (f == FMax);
      is_min  = (f == FMin);
      wr_word = {is_max | is_min, f};
   end

   // Saturation FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_state_q <= StNorm;
      end else begin
         sat_state_q <= sat_state_d;
      end
   end

   // Saturation FSM next state; every valid sample counts, dropped or not
   always_comb begin
      sat_state_d = sat_state_q;
      if (clear) begin
         sat_state_d = StNorm;
      end else if (valid_in) begin
         case (sat_state_q)
            StNorm: begin
               if (is_max)      sat_state_d = StSatPos;
               else if (is_min) sat_state_d = StSatNeg;
            end
            StSatPos: begin
               if (is_min)       sat_state_d = StSatNeg;
               else if (!is_max) sat_state_d = StNorm;
            end
            StSatNeg: begin
               if (is_max)       sat_state_d = StSatPos;
               else if (!is_min) sat_state_d = StNorm;
            end
            default: sat_state_d = StNorm;
         endcase
      end
   end

   // Saturation FSM output: flag each entry into a new saturation rail
   always_comb begin
      sat_evt = 1'b0;
      if (valid_in && !clear) begin
         case (sat_state_q)
            StNorm:   sat_evt = is_max | is_min;
            StSatPos: sat_evt = is_min;
            StSatNeg: sat_evt = is_max;
            default:  sat_evt = 1'b0;
         endcase
      end
   end

   // Saturating event counter next state
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (clear) begin
         sat_cnt_d = '0;
      end else if (sat_evt && (sat_cnt_q != CntMax)) begin
         sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
   end

   // Saturation event counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   // Head tag and statistics outputs
   always_comb begin
      out_sat    = !empty && head_word[WIDTH];
      sat_events = sat_cnt_q;
   end
`else
   // Without tracking the raw sample is stored and the tag is constant
   always_comb begin
      wr_word    = f;
      out_sat    = 1'b0;
      sat_events = '0;
   end
`endif

   // Head and status outputs; data forced to zero while empty
   always_comb begin
      out_valid  = !empty;
      out_data   = empty ? '0 : head_word[WIDTH-1:0];
      level      = level_q;
      overflow   = overflow_q;
      drop_count = drop_cnt_q;
   end

endmodule

// File: tb/tb_mac_result_sink.sv
// Randomized and directed bench for mac_result_sink with a queue-based model.
module tb_mac_result_sink;

   localparam int unsigned W     = 28;
   localparam int unsigned D     = 8;
   localparam int unsigned CW    = 4;
   localparam int unsigned LW    = $clog2(D) + 1;
`ifdef MAC_SINK_SAT_TRACK_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif
   localparam logic [W-1:0] MAXV   = 28'h7FFFFFF;
   localparam logic [W-1:0] MINV   = 28'h8000000;
   localparam int           CNTMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  f;
   logic          valid_in;
   logic [W-1:0]  out_data;
   logic          out_sat;
   logic          out_valid;
   logic          out_ready;
   logic [LW-1:0] level;
   logic          overflow;
   logic [CW-1:0] drop_count;
   logic [CW-1:0] sat_events;
   logic          clear;

   mac_result_sink #(
      .WIDTH (W),
      .DEPTH (D),
      .CNT_W (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .f          (f),
      .valid_in   (valid_in),
      .out_data   (out_data),
      .out_sat    (out_sat),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count),
      .sat_events (sat_events),
      .clear      (clear)
   );

   always #5 clk = ~clk;

   // Reference model: queue of {tag, data}, plain counters, last saturated rail
   logic [W:0] m_q[$];
   bit         m_ovf;
   int         m_drops;
   int         m_sats;
   int         m_rail;   // +1 high rail, -1 low rail, 0 none

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      m_sats  = 0;
      m_rail  = 0;
   endtask

   task automatic model_step(input logic vin, input logic [W-1:0] fv, input logic rdy,
                             input logic clr);
      bit is_full, do_pop, do_push, do_drop, ext;
      int rail;
      is_full = (m_q.size() == D);
      do_pop  = (m_q.size() != 0) && rdy;
      do_push = vin && (!is_full || do_pop);
      do_drop = vin && is_full && !do_pop;
      ext     = (fv == MAXV) || (fv == MINV);
      rail    = (fv == MAXV) ? 1 : ((fv == MINV) ? -1 : 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back({SAT_EN && ext, fv});
      if (clr) begin
         m_ovf   = 1'b0;
         m_drops = 0;
         m_sats  = 0;
         m_rail  = 0;
      end else begin
         if (do_drop) begin
            m_ovf = 1'b1;
            if (m_drops < CNTMAX) m_drops++;
         end
         if (vin) begin
            if (ext && rail != m_rail && SAT_EN && m_sats < CNTMAX) m_sats++;
            m_rail = rail;
         end
      end
   endtask

   task automatic check_outputs(input string ph);
      logic [W:0] head;
      head = (m_q.size() != 0) ? m_q[0] : '0;
      check_eq({ph, ".out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
      check_eq({ph, ".out_data"}, 64'(out_data), 64'(head[W-1:0]));
      check_eq({ph, ".out_sat"}, 64'(out_sat), 64'(head[W]));
      check_eq({ph, ".level"}, 64'(level), 64'(m_q.size()));
      check_eq({ph, ".overflow"}, 64'(overflow), 64'(m_ovf));
      check_eq({ph, ".drop_count"}, 64'(drop_count), 64'(m_drops));
      check_eq({ph, ".sat_events"}, 64'(sat_events), 64'(m_sats));
   endtask

   // One clock: drive at the falling edge, update model at the rising edge, check just after
   task automatic cycle(input string ph, input logic vin, input logic [W-1:0] fv,
                        input logic rdy, input logic clr);
      valid_in  = vin;
      f         = fv;
      out_ready = rdy;
      clear     = clr;
      @(posedge clk);
      model_step(vin, fv, rdy, clr);
      #1;
      check_outputs(ph);
      @(negedge clk);
   endtask

   initial begin
      logic [4:0]   tags;
      logic [W-1:0] rv;
      tags      = 5'b10111;  // expected tags, first sample in bit 0
      reset     = 1'b0;
      valid_in  = 1'b0;
      f         = '0;
      out_ready = 1'b0;
      clear     = 1'b0;
      model_reset();
      #1;
      check_outputs("reset");
      @(negedge clk);
      reset = 1'b1;

      // Single sample
      cycle("single", 1'b1, 28'h0000123, 1'b0, 1'b0);
      check_eq("single.data", 64'(out_data), 64'h123);
      check_eq("single.level", 64'(level), 64'd1);
      cycle("single_pop", 1'b0, '0, 1'b1, 1'b0);
      check_eq("single_pop.valid", 64'(out_valid), 64'd0);

      // Fill past full
      for (int i = 1; i <= 10; i++) cycle("fill", 1'b1, W'(i), 1'b0, 1'b0);
      check_eq("fill.level", 64'(level), 64'd8);
      check_eq("fill.overflow", 64'(overflow), 64'd1);
      check_eq("fill.drops", 64'(drop_count), 64'd2);

      // Clear coinciding with a drop
      cycle("clr_drop", 1'b1, 28'd99, 1'b0, 1'b1);
      check_eq("clr_drop.overflow", 64'(overflow), 64'd0);
      check_eq("clr_drop.drops", 64'(drop_count), 64'd0);
      check_eq("clr_drop.level", 64'(level), 64'd8);

      // Counter saturation
      for (int i = 0; i < 20; i++) cycle("drop20", 1'b1, W'(200 + i), 1'b0, 1'b0);
      check_eq("drop20.drops", 64'(drop_count), 64'(CNTMAX));

      // Drain in order
      for (int i = 1; i <= 8; i++) begin
         check_eq("drain.head", 64'(out_data), 64'(i));
         cycle("drain", 1'b0, '0, 1'b1, 1'b0);
      end

      // Full with simultaneous pop across pointer wrap
      for (int i = 0; i < 8; i++) cycle("refill", 1'b1, W'(100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle("fullpop", 1'b1, W'(300 + i), 1'b1, 1'b0);
      check_eq("fullpop.drops", 64'(drop_count), 64'(CNTMAX));
      check_eq("fullpop.level", 64'(level), 64'd8);
      for (int i = 0; i < 8; i++) cycle("drain2", 1'b0, '0, 1'b1, 1'b0);

      // Saturation sequence
      cycle("sat_clr", 1'b0, '0, 1'b0, 1'b1);
      cycle("sat", 1'b1, MAXV, 1'b0, 1'b0);
      cycle("sat", 1'b1, MAXV, 1'b0, 1'b0);
      cycle("sat", 1'b1, MINV, 1'b0, 1'b0);
      cycle("sat", 1'b1, 28'h0000005, 1'b0, 1'b0);
      cycle("sat", 1'b1, MAXV, 1'b0, 1'b0);
      check_eq("sat.events", 64'(sat_events), SAT_EN ? 64'd3 : 64'd0);
      for (int i = 0; i < 5; i++) begin
         check_eq("sat.tag", 64'(out_sat), 64'(SAT_EN & tags[i]));
         cycle("sat_drain", 1'b0, '0, 1'b1, 1'b0);
      end

      // Asynchronous reset mid-stream
      for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, W'(500 + i), 1'b0, 1'b0);
      check_eq("pre_rst.level", 64'(level), 64'd5);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_outputs("async_rst");
      @(negedge clk);
      reset = 1'b1;
      cycle("post_rst", 1'b1, 28'h55, 1'b0, 1'b0);
      check_eq("post_rst.head", 64'(out_data), 64'h55);
      check_eq("post_rst.level", 64'(level), 64'd1);

      // Random traffic with occasional extremes and clears
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(7))
            0:       rv = MAXV;
            1:       rv = MINV;
            default: rv = W'($urandom);
         endcase
         cycle("rand", 1'($urandom_range(3) != 0), rv, 1'($urandom_range(2) == 0),
               1'($urandom_range(40) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
